// File: rtl/sap3_input_port_if.sv
`default_nettype none
// ============================================================================
// Module      : sap3_input_port_if
// Description : Pin-level and bus-side signal bundle for the SAP-3 input port.
//               The slave modport is the port itself. The master modport is the
//               external agent together with the controller.
//               Optional feature macro: SAP3_IN_PARITY_EN (adds ext_par and
//               parity_err).
// Revision    : 1.0  initial release
// ============================================================================
interface sap3_input_port_if #(
    parameter int DEPTH = 4
) ();
    // External agent side
    logic [7:0]               ext_data;
    logic                     ext_stb;
    logic                     ext_ack;
`ifdef SAP3_IN_PARITY_EN
    logic                     ext_par;
    logic                     parity_err;
`endif
    // Controller / W-bus side
    logic                     rd_en;
    logic [7:0]               bus_out;
    logic                     bus_oe;
    logic                     empty;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;
    logic                     underflow;

`ifdef SAP3_IN_PARITY_EN
    modport slave (
        input  ext_data, ext_stb, ext_par, rd_en,
        output ext_ack, bus_out, bus_oe, empty, full, count, underflow, parity_err
    );
    modport master (
        output ext_data, ext_stb, ext_par, rd_en,
        input  ext_ack, bus_out, bus_oe, empty, full, count, underflow, parity_err
    );
`else
    modport slave (
        input  ext_data, ext_stb, rd_en,
        output ext_ack, bus_out, bus_oe, empty, full, count, underflow
    );
    modport master (
        output ext_data, ext_stb, rd_en,
        input  ext_ack, bus_out, bus_oe, empty, full, count, underflow
    );
`endif
endinterface
`default_nettype wire

// File: rtl/sap3_input_port.sv
`default_nettype none
// ============================================================================
// Module      : sap3_input_port
// Description : Receive half of the SAP-3 pin-level I/O port. An external
//               agent pushes bytes with a 4-phase strobe/ack handshake; the
//               bytes queue in a small FIFO that the controller drains onto
//               the W bus with the IN instruction.
//               Optional feature macro: SAP3_IN_PARITY_EN -- even parity over
//               {ext_data, ext_par}; bad bytes are dropped, flagged in the
//               sticky parity_err, and the handshake still completes.
// Revision    : 1.0  initial release
// ============================================================================
module sap3_input_port #(
    parameter int DEPTH       = 4,   // FIFO entries, power of two, >= 2
    parameter int SYNC_STAGES = 2    // ext_stb synchronizer length, >= 2
) (
    input  logic              CLK,
    input  logic              rst,
    sap3_input_port_if.slave  port_if
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int AW = $clog2(DEPTH);   // pointer width
    localparam int CW = AW + 1;          // occupancy width (0..DEPTH)

    localparam logic [CW-1:0] c_DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] c_CNT_ONE   = CW'(1);
    localparam logic [AW-1:0] c_PTR_ONE   = AW'(1);

    // Handshake FSM encoding
    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_WAIT_SPACE = 2'd1;
    localparam logic [1:0] c_ACK        = 2'd2;

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------------
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sap3_input_port: DEPTH must be a power of two >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("sap3_input_port: SYNC_STAGES must be >= 2");
    end

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    // Strobe synchronizer. fill_q tracks how far valid samples have advanced
    // down the chain since reset, so the zeros left by reset are never
    // mistaken for a real low level of ext_stb.
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   stb_prev_q;
    logic                   w_chain_valid;
    logic                   w_stb_s;
    logic                   w_rise;

    // Handshake FSM
    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic                   ack_q;
    logic                   ack_d;
    logic                   w_capture;   // handshake accepts the byte this cycle
    logic                   w_par_ok;
    logic                   w_push;      // byte actually enters the FIFO

    // FIFO
    logic [7:0]             mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q;
    logic [AW-1:0]          rd_ptr_d;
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          count_d;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_space;

    // Sticky status
    logic                   underflow_q;
    logic                   underflow_d;
`ifdef SAP3_IN_PARITY_EN
    logic                   parity_err_q;
    logic                   parity_err_d;
`endif

    // ------------------------------------------------------------------------
    // Strobe synchronizer and rising-edge detect
    // ------------------------------------------------------------------------
    assign w_stb_s       = sync_q[SYNC_STAGES-1];
    assign w_chain_valid = fill_q[SYNC_STAGES-1];
    // stb_prev resets high so a strobe still asserted across reset must go
    // low and high again before it is taken as a new byte.
    assign w_rise        = w_chain_valid & w_stb_s & ~stb_prev_q;

    // Shift ext_stb through the synchronizer and remember the last valid level
    always_ff @(posedge CLK) begin
        if (rst) begin
            sync_q     <= '0;
            fill_q     <= '0;
            stb_prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], port_if.ext_stb};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            if (w_chain_valid) begin
                stb_prev_q <= w_stb_s;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO status and read qualification
    // ------------------------------------------------------------------------
    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == c_DEPTH_CNT);
    assign w_pop   = port_if.rd_en & ~w_empty;
    // A pop in the same cycle frees the slot the write needs, so a full FIFO
    // can still accept when the controller is reading.
    assign w_space = ~w_full | w_pop;

    // ------------------------------------------------------------------------
    // Parity qualification of the incoming byte
    // ------------------------------------------------------------------------
`ifdef SAP3_IN_PARITY_EN
    assign w_par_ok = ~(^{port_if.ext_data, port_if.ext_par});
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_push = w_capture & w_par_ok;

    // ------------------------------------------------------------------------
    // Handshake FSM next-state: decide capture, ack and state transitions
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ack_d     = ack_q;
        w_capture = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (w_rise) begin
                    if (w_space) begin
                        w_capture = 1'b1;
                        ack_d     = 1'b1;
                        state_d   = c_ACK;
                    end else begin
                        state_d   = c_WAIT_SPACE;
                    end
                end
            end
            c_WAIT_SPACE: begin
                // ext_data is held by the agent until ack, so it is still
                // valid here; room takes priority over a late withdrawal.
                if (w_space) begin
                    w_capture = 1'b1;
                    ack_d     = 1'b1;
                    state_d   = c_ACK;
                end else if (!w_stb_s) begin
                    state_d   = c_IDLE;
                end
            end
            c_ACK: begin
                if (!w_stb_s) begin
                    ack_d   = 1'b0;
                    state_d = c_IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = c_IDLE;
            end
        endcase
    end

    // Register the handshake state and acknowledge
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= c_IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointer/occupancy next-state
    // ------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;   // wraps modulo DEPTH
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_ONE;
            2'b01:   count_d = count_q - c_CNT_ONE;
            default: count_d = count_q;        // idle, or write and pop together
        endcase
    end

    // Register FIFO pointers and occupancy
    always_ff @(posedge CLK) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Store accepted bytes; storage needs no reset because reads are gated
    // by occupancy.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= port_if.ext_data;
        end
    end

    // ------------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------------
    assign underflow_d = underflow_q | (port_if.rd_en & w_empty);
`ifdef SAP3_IN_PARITY_EN
    assign parity_err_d = parity_err_q | (w_capture & ~w_par_ok);
`endif

    // Hold error flags until reset
    always_ff @(posedge CLK) begin
        if (rst) begin
            underflow_q  <= 1'b0;
`ifdef SAP3_IN_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            underflow_q  <= underflow_d;
`ifdef SAP3_IN_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // The head byte is presented combinationally during the rd_en cycle and
    // the read pointer advances at the closing edge.
    assign port_if.bus_oe    = w_pop;
    assign port_if.bus_out   = w_pop ? mem_q[rd_ptr_q] : 8'h00;
    assign port_if.ext_ack   = ack_q;
    assign port_if.empty     = w_empty;
    assign port_if.full      = w_full;
    assign port_if.count     = count_q;
    assign port_if.underflow = underflow_q;
`ifdef SAP3_IN_PARITY_EN
    assign port_if.parity_err = parity_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sap3_input_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_sap3_input_port
// Description : Directed self-checking bench for sap3_input_port. Inputs are
//               driven just after the falling edge and outputs are sampled at
//               the falling edge (or 1 ns after a combinational change).
//               Optional feature macro: SAP3_IN_PARITY_EN enables the parity
//               steps.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sap3_input_port;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sap3_input_port_if #(.DEPTH(DEPTH)) p ();

    sap3_input_port #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .CLK     (clk),
        .rst     (rst),
        .port_if (p.slave)
    );

    // One comparison: count it, and on mismatch count and report it.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full 4-phase handshake for one byte, with bounded waits.
    task automatic push(input logic [7:0] d);
        int n;
        p.ext_data = d;
        p.ext_stb  = 1'b1;
        n = 0;
        while (p.ext_ack !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("push_ack_rise", 32'(p.ext_ack), 32'd1);
        p.ext_stb = 1'b0;
        n = 0;
        while (p.ext_ack !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("push_ack_fall", 32'(p.ext_ack), 32'd0);
    endtask

    // Single rd_en cycle, checking the byte presented on the bus.
    task automatic pop_expect(input string tag, input logic [7:0] exp);
        p.rd_en = 1'b1;
        #1;
        check({tag, "_oe"}, 32'(p.bus_oe), 32'd1);
        check({tag, "_data"}, 32'(p.bus_out), 32'(exp));
        @(negedge clk);
        p.rd_en = 1'b0;
    endtask

    // Hard stop if anything stalls beyond all reasonable bounds.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] drain_exp [4];
        int n;
        drain_exp[0] = 8'h22;
        drain_exp[1] = 8'h33;
        drain_exp[2] = 8'h44;
        drain_exp[3] = 8'h55;

        p.ext_data = 8'h00;
        p.ext_stb  = 1'b0;
        p.rd_en    = 1'b0;
`ifdef SAP3_IN_PARITY_EN
        p.ext_par  = 1'b0;
`endif
        rst = 1'b1;

        // ---- Reset state ----
        repeat (2) @(negedge clk);
        check("rst_ack",       32'(p.ext_ack),   32'd0);
        check("rst_empty",     32'(p.empty),     32'd1);
        check("rst_full",      32'(p.full),      32'd0);
        check("rst_count",     32'(p.count),     32'd0);
        check("rst_bus_out",   32'(p.bus_out),   32'h00);
        check("rst_bus_oe",    32'(p.bus_oe),    32'd0);
        check("rst_underflow", 32'(p.underflow), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // ---- Single byte with exact ack latency ----
        p.ext_data = 8'hA5;
        p.ext_stb  = 1'b1;
        @(negedge clk);
        check("lat_edge1_ack", 32'(p.ext_ack), 32'd0);
        @(negedge clk);
        check("lat_edge2_ack", 32'(p.ext_ack), 32'd0);
        @(negedge clk);
        check("lat_edge3_ack", 32'(p.ext_ack), 32'd1);
        check("a5_count",      32'(p.count),   32'd1);
        check("a5_empty",      32'(p.empty),   32'd0);
        p.ext_stb = 1'b0;
        @(negedge clk);
        check("fall_edge1_ack", 32'(p.ext_ack), 32'd1);
        @(negedge clk);
        check("fall_edge2_ack", 32'(p.ext_ack), 32'd1);
        @(negedge clk);
        check("fall_edge3_ack", 32'(p.ext_ack), 32'd0);
        pop_expect("a5_read", 8'hA5);
        check("a5_after_empty", 32'(p.empty),   32'd1);
        check("a5_after_oe",    32'(p.bus_oe),  32'd0);
        check("a5_after_bus",   32'(p.bus_out), 32'h00);

        // ---- Fill to full, 5th byte waits for space ----
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        check("fill_full",  32'(p.full),  32'd1);
        check("fill_count", 32'(p.count), 32'd4);
        p.ext_data = 8'h55;
        p.ext_stb  = 1'b1;
        repeat (6) @(negedge clk);
        check("wait_space_ack",   32'(p.ext_ack), 32'd0);
        check("wait_space_count", 32'(p.count),   32'd4);
        // Pop on the same cycle as the pending write: both happen.
        p.rd_en = 1'b1;
        #1;
        check("full_pop_data", 32'(p.bus_out), 32'h11);
        check("full_pop_oe",   32'(p.bus_oe),  32'd1);
        check("full_pop_ack",  32'(p.ext_ack), 32'd0);
        @(negedge clk);
        p.rd_en = 1'b0;
        check("ws_write_ack",   32'(p.ext_ack), 32'd1);
        check("ws_write_count", 32'(p.count),   32'd4);
        check("ws_write_full",  32'(p.full),    32'd1);
        p.ext_stb = 1'b0;
        n = 0;
        while (p.ext_ack !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ws_ack_fall", 32'(p.ext_ack), 32'd0);
        for (int i = 0; i < 4; i++) begin
            pop_expect($sformatf("drain%0d", i), drain_exp[i]);
        end
        check("drain_empty", 32'(p.empty), 32'd1);
        check("drain_count", 32'(p.count), 32'd0);

        // ---- Read while empty ----
        p.rd_en = 1'b1;
        #1;
        check("uf_bus_out", 32'(p.bus_out), 32'h00);
        check("uf_bus_oe",  32'(p.bus_oe),  32'd0);
        @(negedge clk);
        p.rd_en = 1'b0;
        check("uf_flag",  32'(p.underflow), 32'd1);
        check("uf_count", 32'(p.count),     32'd0);
        repeat (3) @(negedge clk);
        check("uf_sticky", 32'(p.underflow), 32'd1);

        // ---- Reset in the middle of a handshake ----
        p.ext_data = 8'h77;
        p.ext_stb  = 1'b1;
        n = 0;
        while (p.ext_ack !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_ack_rise", 32'(p.ext_ack), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ack",   32'(p.ext_ack),   32'd0);
        check("mid_rst_count", 32'(p.count),     32'd0);
        check("mid_rst_uf",    32'(p.underflow), 32'd0);
        repeat (8) @(negedge clk);
        check("no_recapture_ack",   32'(p.ext_ack), 32'd0);
        check("no_recapture_count", 32'(p.count),   32'd0);
        p.ext_stb = 1'b0;
        repeat (4) @(negedge clk);
        push(8'h66);
        check("post_rst_count", 32'(p.count), 32'd1);
        pop_expect("post_rst_read", 8'h66);

`ifdef SAP3_IN_PARITY_EN
        // ---- Parity: bad byte dropped, good byte kept ----
        p.ext_par = 1'b0;
        push(8'h01);
        check("par_bad_err",   32'(p.parity_err), 32'd1);
        check("par_bad_count", 32'(p.count),      32'd0);
        p.ext_par = 1'b1;
        push(8'h01);
        check("par_good_count",  32'(p.count),      32'd1);
        check("par_err_sticky",  32'(p.parity_err), 32'd1);
        pop_expect("par_good_read", 8'h01);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
